// File: rtl/stack_cpu_pkg.sv
// -----------------------------------------------------------------------------
// stack_cpu_pkg
// Shared definitions for the 8-bit stack machine sequencer:
//   - DEF_AW / DEF_DW : default address / data widths
//   - OP_*            : 3-bit opcode encodings (instruction bits [7:5])
//   - state_t         : multicycle FSM state encoding
// -----------------------------------------------------------------------------
package stack_cpu_pkg;

    localparam int DEF_AW = 5;
    localparam int DEF_DW = 8;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IF,
        ST_ID,
        ST_MRD,
        ST_PSH,
        ST_POPS,
        ST_MWR,
        ST_JMP,
        ST_TOS,
        ST_JZC,
        ST_POPA,
        ST_POPB,
        ST_EXE,
        ST_PSHR
    } state_t;

endpackage

// File: rtl/stack_cpu_sequencer_if.sv
// -----------------------------------------------------------------------------
// stack_cpu_sequencer_if
// Memory and stack control bus between the sequencer and its two slaves.
//   master (sequencer): drives mem_addr, mem_wdata, memread, memwrite,
//                       stk_din, push, pop, tos; receives mem_rdata, stk_dout
//   slave  (mem/stack): the reverse
// mem_rdata is valid the cycle after memread; stk_dout the cycle after
// pop/tos.
// -----------------------------------------------------------------------------
interface stack_cpu_sequencer_if
    import stack_cpu_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          memread;
    logic          memwrite;
    logic [DW-1:0] stk_din;
    logic [DW-1:0] stk_dout;
    logic          push;
    logic          pop;
    logic          tos;

    modport master (
        output mem_addr, mem_wdata, memread, memwrite,
        output stk_din, push, pop, tos,
        input  mem_rdata, stk_dout
    );

    modport slave (
        input  mem_addr, mem_wdata, memread, memwrite,
        input  stk_din, push, pop, tos,
        output mem_rdata, stk_dout
    );
endinterface

// File: rtl/register.sv
// -----------------------------------------------------------------------------
// register
// Generic loadable register with synchronous active-high reset.
//   clk : clock
//   rst : synchronous reset, active high (clears q)
//   ld  : load enable, q <= d when high
//   d   : data in
//   q   : data out
// -----------------------------------------------------------------------------
module register #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end
endmodule

// File: rtl/stack_alu.sv
// -----------------------------------------------------------------------------
// stack_alu
// Combinational ALU for the stack machine. b is the old next-of-stack,
// a the old top, so SUB is b - a. Results wrap mod 2^DW, no flags.
//   op     : 00 ADD, 01 SUB, 10 AND, 11 NOT (~b)
//   a, b   : operands
//   result : DW-bit result
// -----------------------------------------------------------------------------
module stack_alu #(
    parameter int DW = 8
) (
    input  logic [1:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result
);
    always_comb begin
        result = '0;
        case (op)
            2'b00:   result = b + a;
            2'b01:   result = b - a;
            2'b10:   result = b & a;
            default: result = ~b;
        endcase
    end
endmodule

// File: rtl/stack_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// stack_cpu_sequencer
// Multicycle fetch/decode/execute sequencer for the 8-bit stack machine.
// Owns PC, IR and the ALU operand registers A/B and issues every memory
// and stack strobe in the core.
//   clk        : clock, rising edge
//   rst        : synchronous reset, active LOW; while low all outputs are 0
//   bus        : master side of the memory/stack control bus
//   pc         : current PC (debug)
//   instr_done : pulse in the last cycle of every instruction
// -----------------------------------------------------------------------------
module stack_cpu_sequencer
    import stack_cpu_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic                  clk,
    input  logic                  rst,
    stack_cpu_sequencer_if.master bus,
    output logic [AW-1:0]         pc,
    output logic                  instr_done
);
    state_t        state_q, state_d;

    logic          rst_h;
    logic [AW-1:0] pc_q, pc_d;
    logic          pc_ld;
    logic [DW-1:0] ir_q, a_q, b_q;
    logic          ir_ld, a_ld, b_ld;

    logic [AW-1:0] ir_addr;
    logic [2:0]    ir_op;
    logic [2:0]    rd_op;
    logic [DW-1:0] alu_result;
    logic          stk_zero;

    logic [AW-1:0] mem_addr_c;
    logic [DW-1:0] mem_wdata_c;
    logic          memread_c, memwrite_c;
    logic [DW-1:0] stk_din_c;
    logic          push_c, pop_c, tos_c, done_c;

    assign rst_h    = ~rst;
    assign ir_addr  = ir_q[AW-1:0];
    assign ir_op    = ir_q[DW-1:DW-3];
    // Decode in ID looks at the fetched word directly; IR loads at the
    // end of that same cycle.
    assign rd_op    = bus.mem_rdata[DW-1:DW-3];
    assign stk_zero = (bus.stk_dout == '0);

    // ---------------- datapath registers ----------------
    register #(.W(AW)) u_pc (.clk(clk), .rst(rst_h), .ld(pc_ld), .d(pc_d),          .q(pc_q));
    register #(.W(DW)) u_ir (.clk(clk), .rst(rst_h), .ld(ir_ld), .d(bus.mem_rdata), .q(ir_q));
    register #(.W(DW)) u_a  (.clk(clk), .rst(rst_h), .ld(a_ld),  .d(bus.stk_dout),  .q(a_q));
    register #(.W(DW)) u_b  (.clk(clk), .rst(rst_h), .ld(b_ld),  .d(bus.stk_dout),  .q(b_q));

    stack_alu #(.DW(DW)) u_alu (
        .op     (ir_op[1:0]),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result)
    );

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = ST_IF;
            ST_IF:   state_d = ST_ID;
            ST_ID: begin
                case (rd_op)
                    OP_PUSH: state_d = ST_MRD;
                    OP_POP:  state_d = ST_POPS;
                    OP_JMP:  state_d = ST_JMP;
                    OP_JZ:   state_d = ST_TOS;
                    default: state_d = ST_POPA;   // ADD/SUB/AND/NOT
                endcase
            end
            ST_MRD:  state_d = ST_PSH;
            ST_PSH:  state_d = ST_IF;
            ST_POPS: state_d = ST_MWR;
            ST_MWR:  state_d = ST_IF;
            ST_JMP:  state_d = ST_IF;
            ST_TOS:  state_d = ST_JZC;
            ST_JZC:  state_d = ST_IF;
            // NOT needs only one operand, so it skips the second pop.
            ST_POPA: state_d = (ir_op == OP_NOT) ? ST_EXE : ST_POPB;
            ST_POPB: state_d = ST_EXE;
            ST_EXE:  state_d = ST_PSHR;
            ST_PSHR: state_d = ST_IF;
            default: state_d = ST_INIT;
        endcase
    end

    // ---------------- register load controls ----------------
    // A captures the first popped value (old top) in POPB, B the second
    // (old next) in EXE; each is the data returned for the previous pop.
    always_comb begin
        pc_ld = 1'b0;
        pc_d  = pc_q;
        ir_ld = 1'b0;
        a_ld  = 1'b0;
        b_ld  = 1'b0;
        case (state_q)
            ST_ID: begin
                ir_ld = 1'b1;
                pc_ld = 1'b1;
                pc_d  = pc_q + {{(AW-1){1'b0}}, 1'b1};
            end
            ST_JMP: begin
                pc_ld = 1'b1;
                pc_d  = ir_addr;
            end
            ST_JZC: begin
                pc_ld = stk_zero;
                pc_d  = ir_addr;
            end
            ST_POPB: a_ld = 1'b1;
            ST_EXE:  b_ld = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Moore strobes and data muxes ----------------
    // Everything is held at 0 while rst is low, whatever the state.
    always_comb begin
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        memread_c   = 1'b0;
        memwrite_c  = 1'b0;
        stk_din_c   = '0;
        push_c      = 1'b0;
        pop_c       = 1'b0;
        tos_c       = 1'b0;
        done_c      = 1'b0;
        if (rst) begin
            case (state_q)
                ST_IF: begin
                    memread_c  = 1'b1;
                    mem_addr_c = pc_q;
                end
                ST_MRD: begin
                    memread_c  = 1'b1;
                    mem_addr_c = ir_addr;
                end
                ST_PSH: begin
                    push_c    = 1'b1;
                    stk_din_c = bus.mem_rdata;
                    done_c    = 1'b1;
                end
                ST_POPS: pop_c = 1'b1;
                ST_MWR: begin
                    memwrite_c  = 1'b1;
                    mem_addr_c  = ir_addr;
                    mem_wdata_c = bus.stk_dout;
                    done_c      = 1'b1;
                end
                ST_JMP:  done_c = 1'b1;
                ST_TOS:  tos_c  = 1'b1;
                ST_JZC:  done_c = 1'b1;
                ST_POPA: pop_c  = 1'b1;
                ST_POPB: pop_c  = 1'b1;
                ST_PSHR: begin
                    push_c    = 1'b1;
                    stk_din_c = alu_result;
                    done_c    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.memread   = memread_c;
    assign bus.memwrite  = memwrite_c;
    assign bus.stk_din   = stk_din_c;
    assign bus.push      = push_c;
    assign bus.pop       = pop_c;
    assign bus.tos       = tos_c;
    assign instr_done    = done_c;
    assign pc            = rst ? pc_q : '0;

endmodule

// File: tb/tb_stack_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stack_cpu_sequencer
// Directed programs run against behavioural models of the 32x8 memory and
// the 32-deep stack. Expected strobe events (kind, address, data, cycle since
// reset release) are queued before each run; a negedge monitor pops and
// compares every observed event, checks the bus protocol and the forced-zero
// outputs during reset, and evaluates post-run memory/stack checks.
// -----------------------------------------------------------------------------
module tb_stack_cpu_sequencer;
    import stack_cpu_pkg::*;

    localparam int AW = DEF_AW;
    localparam int DW = DEF_DW;

    localparam logic [2:0] EV_RD   = 3'd0;
    localparam logic [2:0] EV_WR   = 3'd1;
    localparam logic [2:0] EV_PUSH = 3'd2;
    localparam logic [2:0] EV_POP  = 3'd3;
    localparam logic [2:0] EV_TOS  = 3'd4;
    localparam logic [2:0] EV_DONE = 3'd5;

    localparam logic [1:0] CK_MEM    = 2'd0;
    localparam logic [1:0] CK_SP     = 2'd1;
    localparam logic [1:0] CK_TOP    = 2'd2;
    localparam logic [1:0] CK_QEMPTY = 2'd3;

    // Values returned when the DUT has not requested a read; a sequencer
    // sampling at the wrong time picks these up and corrupts its results.
    localparam logic [DW-1:0] MEM_POISON = 8'h5A;
    localparam logic [DW-1:0] STK_POISON = 8'hA5;

    typedef struct packed {
        logic [2:0]    kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [15:0]   t;
    } ev_t;

    typedef struct packed {
        logic [1:0]    kind;
        logic [4:0]    idx;
        logic [DW-1:0] val;
    } ck_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic load = 1'b0;
    always #5 clk = ~clk;

    stack_cpu_sequencer_if #(.AW(AW), .DW(DW)) bus ();
    logic [AW-1:0] pc;
    logic          instr_done;

    stack_cpu_sequencer #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .pc         (pc),
        .instr_done (instr_done)
    );

    // ---------------- memory and stack models ----------------
    logic [DW-1:0] init_mem [32];
    logic [DW-1:0] init_stk [32];
    logic [4:0]    init_sp;
    logic [DW-1:0] mem [32];
    logic [DW-1:0] stk [32];
    logic [4:0]    sp;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= init_mem[i];
                stk[i] <= init_stk[i];
            end
            sp            <= init_sp;
            bus.mem_rdata <= MEM_POISON;
            bus.stk_dout  <= STK_POISON;
        end else begin
            bus.mem_rdata <= bus.memread ? mem[bus.mem_addr] : MEM_POISON;
            if (bus.memwrite) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.stk_dout <= STK_POISON;
            if (bus.push) begin
                stk[sp] <= bus.stk_din;
                sp      <= sp + 5'd1;
            end else if (bus.pop) begin
                bus.stk_dout <= stk[sp - 5'd1];
                sp           <= sp - 5'd1;
            end else if (bus.tos) begin
                bus.stk_dout <= stk[sp - 5'd1];
            end
        end
    end

    // ---------------- scoreboard ----------------
    ev_t exp_q[$];
    ck_t chk_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  t_cnt = 0;

    function automatic string kname(input logic [2:0] k);
        case (k)
            EV_RD:   return "RD";
            EV_WR:   return "WR";
            EV_PUSH: return "PUSH";
            EV_POP:  return "POP";
            EV_TOS:  return "TOS";
            default: return "DONE";
        endcase
    endfunction

    task automatic exp(input logic [2:0] k, input int a, input int d, input int t);
        ev_t e;
        e.kind = k;
        e.addr = AW'(a);
        e.data = DW'(d);
        e.t    = 16'(t);
        exp_q.push_back(e);
    endtask

    task automatic post(input logic [1:0] k, input int idx, input int val);
        ck_t c;
        c.kind = k;
        c.idx  = 5'(idx);
        c.val  = DW'(val);
        chk_q.push_back(c);
    endtask

    task automatic observe(input logic [2:0] k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ev_t got, want;
        got.kind = k;
        got.addr = a;
        got.data = d;
        got.t    = 16'(t_cnt);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL event_unexpected: got %s a=%0d d=%02h t=%0d, required no event",
                     kname(k), a, d, t_cnt);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_bad++;
                $display("FAIL event_%s: got %s a=%0d d=%02h t=%0d, required %s a=%0d d=%02h t=%0d",
                         kname(want.kind), kname(got.kind), got.addr, got.data, got.t,
                         kname(want.kind), want.addr, want.data, want.t);
            end else begin
                $display("ok  t=%0d %s a=%0d d=%02h", t_cnt, kname(k), a, d);
            end
        end
    endtask

    task automatic run_check(input ck_t c);
        logic [DW-1:0] got;
        n_cmp++;
        case (c.kind)
            CK_MEM: begin
                got = mem[c.idx];
                if (got !== c.val) begin
                    n_bad++;
                    $display("FAIL mem[%0d]: got %02h required %02h", c.idx, got, c.val);
                end else $display("ok  mem[%0d]=%02h", c.idx, got);
            end
            CK_SP: begin
                if (sp !== c.val[4:0]) begin
                    n_bad++;
                    $display("FAIL stack_depth: got %0d required %0d", sp, c.val[4:0]);
                end else $display("ok  stack_depth=%0d", sp);
            end
            CK_TOP: begin
                got = stk[sp - 5'd1];
                if (got !== c.val) begin
                    n_bad++;
                    $display("FAIL stack_top: got %02h required %02h", got, c.val);
                end else $display("ok  stack_top=%02h", got);
            end
            default: begin
                if (exp_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL missing_events: got %0d still pending required 0", exp_q.size());
                    exp_q.delete();
                end else $display("ok  all expected events seen");
            end
        endcase
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            t_cnt = 0;
            n_cmp++;
            if ({bus.mem_addr, bus.mem_wdata, bus.memread, bus.memwrite, bus.stk_din,
                 bus.push, bus.pop, bus.tos, pc, instr_done} != '0) begin
                n_bad++;
                $display("FAIL reset_outputs: got ma=%0d wd=%02h rd=%b wr=%b din=%02h psh=%b pop=%b tos=%b pc=%0d done=%b required all 0",
                         bus.mem_addr, bus.mem_wdata, bus.memread, bus.memwrite, bus.stk_din,
                         bus.push, bus.pop, bus.tos, pc, instr_done);
            end
            while (chk_q.size() > 0) run_check(chk_q.pop_front());
        end else begin
            if (t_cnt == 0) begin
                n_cmp++;
                if (pc !== '0) begin
                    n_bad++;
                    $display("FAIL pc_after_reset: got %0d required 0", pc);
                end
            end
            n_cmp++;
            if (bus.memread && bus.memwrite) begin
                n_bad++;
                $display("FAIL mem_strobes: got memread=1 memwrite=1 required at most one");
            end
            n_cmp++;
            if ($countones({bus.push, bus.pop, bus.tos}) > 1) begin
                n_bad++;
                $display("FAIL stack_strobes: got push=%b pop=%b tos=%b required at most one",
                         bus.push, bus.pop, bus.tos);
            end
            if (bus.memread)  observe(EV_RD,   bus.mem_addr, '0);
            if (bus.memwrite) observe(EV_WR,   bus.mem_addr, bus.mem_wdata);
            if (bus.push)     observe(EV_PUSH, '0,           bus.stk_din);
            if (bus.pop)      observe(EV_POP,  '0,           '0);
            if (bus.tos)      observe(EV_TOS,  '0,           '0);
            if (instr_done)   observe(EV_DONE, pc,           '0);
            t_cnt = t_cnt + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_images();
        for (int i = 0; i < 32; i++) begin
            init_mem[i] = '0;
            init_stk[i] = '0;
        end
        init_sp = '0;
    endtask

    // Called with rst low; copies the images into the models.
    task automatic load_images();
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
    endtask

    // Release reset for n cycles (t = 0 .. n-1), then reassert it.
    task automatic run_cycles(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        post(CK_QEMPTY, 0, 0);
    endtask

    initial begin
        // Arithmetic: PUSH 20, PUSH 21, SUB, POP 22 -> mem[22] = 9 - 3
        clear_images();
        init_mem[0] = 8'h94; init_mem[1] = 8'h95; init_mem[2] = 8'h20; init_mem[3] = 8'hB6;
        init_mem[20] = 8'd9; init_mem[21] = 8'd3;
        load_images();
        exp(EV_RD, 0, 0, 1);  exp(EV_RD, 20, 0, 3);  exp(EV_PUSH, 0, 9, 4);  exp(EV_DONE, 1, 0, 4);
        exp(EV_RD, 1, 0, 5);  exp(EV_RD, 21, 0, 7);  exp(EV_PUSH, 0, 3, 8);  exp(EV_DONE, 2, 0, 8);
        exp(EV_RD, 2, 0, 9);  exp(EV_POP, 0, 0, 11); exp(EV_POP, 0, 0, 12);
        exp(EV_PUSH, 0, 6, 14); exp(EV_DONE, 3, 0, 14);
        exp(EV_RD, 3, 0, 15); exp(EV_POP, 0, 0, 17); exp(EV_WR, 22, 6, 18); exp(EV_DONE, 4, 0, 18);
        run_cycles(19);
        post(CK_MEM, 22, 6); post(CK_SP, 0, 0);

        // JZ taken: PUSH 20 (=0), JZ 7
        clear_images();
        init_mem[0] = 8'h94; init_mem[1] = 8'hE7; init_mem[20] = 8'd0;
        load_images();
        exp(EV_RD, 0, 0, 1); exp(EV_RD, 20, 0, 3); exp(EV_PUSH, 0, 0, 4); exp(EV_DONE, 1, 0, 4);
        exp(EV_RD, 1, 0, 5); exp(EV_TOS, 0, 0, 7); exp(EV_DONE, 2, 0, 8); exp(EV_RD, 7, 0, 9);
        run_cycles(10);
        post(CK_SP, 0, 1);

        // JZ not taken: PUSH 20 (=5), JZ 7
        clear_images();
        init_mem[0] = 8'h94; init_mem[1] = 8'hE7; init_mem[20] = 8'd5;
        load_images();
        exp(EV_RD, 0, 0, 1); exp(EV_RD, 20, 0, 3); exp(EV_PUSH, 0, 5, 4); exp(EV_DONE, 1, 0, 4);
        exp(EV_RD, 1, 0, 5); exp(EV_TOS, 0, 0, 7); exp(EV_DONE, 2, 0, 8); exp(EV_RD, 2, 0, 9);
        run_cycles(10);
        post(CK_SP, 0, 1); post(CK_TOP, 0, 5);

        // JMP 31, NOT at 31 on preloaded 0x0F, PC wraps to 0
        clear_images();
        init_mem[0] = 8'hDF; init_mem[31] = 8'h60;
        init_stk[0] = 8'h0F; init_sp = 5'd1;
        load_images();
        exp(EV_RD, 0, 0, 1); exp(EV_DONE, 1, 0, 3); exp(EV_RD, 31, 0, 4); exp(EV_POP, 0, 0, 6);
        exp(EV_PUSH, 0, 8'hF0, 8); exp(EV_DONE, 0, 0, 8); exp(EV_RD, 0, 0, 9);
        run_cycles(10);
        post(CK_SP, 0, 1); post(CK_TOP, 0, 8'hF0);

        // AND: next=0xF0, top=0x33 -> 0x30
        clear_images();
        init_mem[0] = 8'h40;
        init_stk[0] = 8'hF0; init_stk[1] = 8'h33; init_sp = 5'd2;
        load_images();
        exp(EV_RD, 0, 0, 1); exp(EV_POP, 0, 0, 3); exp(EV_POP, 0, 0, 4);
        exp(EV_PUSH, 0, 8'h30, 6); exp(EV_DONE, 1, 0, 6); exp(EV_RD, 1, 0, 7);
        run_cycles(8);
        post(CK_SP, 0, 1); post(CK_TOP, 0, 8'h30);

        // ADD overflow: 0xF0 + 0x33 = 0x123 -> 0x23
        clear_images();
        init_mem[0] = 8'h00;
        init_stk[0] = 8'hF0; init_stk[1] = 8'h33; init_sp = 5'd2;
        load_images();
        exp(EV_RD, 0, 0, 1); exp(EV_POP, 0, 0, 3); exp(EV_POP, 0, 0, 4);
        exp(EV_PUSH, 0, 8'h23, 6); exp(EV_DONE, 1, 0, 6); exp(EV_RD, 1, 0, 7);
        run_cycles(8);
        post(CK_SP, 0, 1); post(CK_TOP, 0, 8'h23);

        // Reset during EXE of ADD (t=5): no push, restart fetch at 0
        clear_images();
        init_mem[0] = 8'h00;
        init_stk[0] = 8'hF0; init_stk[1] = 8'h33; init_sp = 5'd2;
        load_images();
        exp(EV_RD, 0, 0, 1); exp(EV_POP, 0, 0, 3); exp(EV_POP, 0, 0, 4);
        run_cycles(5);
        repeat (2) @(posedge clk);
        #1;
        exp(EV_RD, 0, 0, 1);
        run_cycles(2);
        post(CK_SP, 0, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stack_cpu_sequencer.md
# stack_cpu_sequencer

Multicycle fetch/decode/execute sequencer for the 8-bit stack machine. Owns PC, IR and the two ALU operand registers. Drives the 32×8 data/instruction memory (synchronous read) and the 32-deep stack (push/pop/tos) through their control ports. Sits directly upstream of both: every memread/memwrite and push/pop/tos in the core is issued here.

## Interface
- `AW`, 5: memory address / PC width
- `DW`, 8: data and instruction width
- `clk`  in  1: clock, rising edge
- `rst`  in  1: synchronous, active-low reset
- `mem_addr`  out  AW: memory address
- `mem_wdata`  out  DW: memory write data
- `mem_rdata`  in  DW: memory read data, valid the cycle after `memread`
- `memread`, `memwrite`  out  1: memory strobes
- `stk_din`  out  DW: stack push data
- `stk_dout`  in  DW: stack output, valid the cycle after `pop`/`tos`
- `push`, `pop`, `tos`  out  1: stack strobes, one-cycle pulses
- `pc`  out  AW: current PC (debug)
- `instr_done`  out  1: pulse in the last cycle of every instruction

## Operation
- Instruction format: opcode `[7:5]`, address `[4:0]`. Encodings:
  - ADD 000, SUB 001, AND 010, NOT 011
  - PUSH 100, POP 101, JMP 110, JZ 111
- Every decoded opcode is legal; there is no halt.
- FSM states: INIT, IF, ID, MRD, PSH, POPS, MWR, JMP, TOS, JZC, POPA, POPB, EXE, PSHR.
- Common sequence: INIT→IF. In IF: `memread=1`, `mem_addr=pc`. In ID: IR←`mem_rdata`, pc←pc+1 (mod 32), then branch on opcode.
- PUSH: ID→MRD (`memread`, `mem_addr=ir[4:0]`)→PSH (`push`, `stk_din=mem_rdata`)→IF.
- POP: ID→POPS (`pop`)→MWR (`memwrite`, `mem_addr=ir[4:0]`, `mem_wdata=stk_dout`)→IF.
- JMP: ID→JMP (pc←ir[4:0])→IF.
- JZ: ID→TOS (`tos`)→JZC (if `stk_dout==0`, pc←ir[4:0]) →IF. JZ never changes stack depth.
- Binary ALU ops: ID→POPA (`pop`)→POPB (`pop`, A←`stk_dout`)→EXE (B←`stk_dout`)→PSHR (`push`, `stk_din=result`)→IF.
  - A holds the old top; B holds the old next.
  - ADD: B+A. SUB: B−A. AND: B&A. All mod 2^8, no flags.
- NOT: ID→POPA→EXE (B←`stk_dout`)→PSHR with result ~B.
- `instr_done`=1 in PSH, MWR, JMP, JZC, PSHR.
- All strobes and data outputs not listed for a state are 0.
- Stack overflow/underflow is not detected; the stack wraps by design.

## Timing
- `rst`=0 at an edge: state←INIT; pc, IR, A, B ←0.
- While `rst`=0, every output is forced to 0 combinationally, including `pc`. No strobe is issued in the reset cycle, even mid-instruction.
- First fetch (`memread=1`, `mem_addr=0`) occurs in the second cycle after `rst` returns to 1 (INIT, then IF).
- Cycles per instruction, IF through last state:
  - PUSH 4, POP 4, JMP 3, JZ 4, NOT 5, ADD/SUB/AND 6.
- PC wraps 31→0 on increment. A taken JZ/JMP overrides the increment made in ID.
- Outputs are Moore, decoded from the state register, except the data muxes, which are combinational from IR/A/B/`mem_rdata`/`stk_dout`.
- `memread` and `memwrite` are never asserted together. At most one of `push`/`pop`/`tos` is asserted per cycle.

## Structure
- Package `stack_cpu_pkg` holds:
  - opcode localparams
  - state encoding enum
  - `AW`/`DW` defaults
- PC, IR, A and B use the existing `register` module. Its active-high reset is driven by `~rst`, with `ld` per state.
- One combinational sub-module, `stack_alu`, takes (`op[1:0]`, `a`, `b`) and produces `result[7:0]`.
- Everything else (FSM, muxes) lives in the top.

## Test plan
- Arithmetic program:
  - Memory: `[0]=0x94` (PUSH 20), `[1]=0x95` (PUSH 21), `[2]=0x20` (SUB), `[3]=0xB6` (POP 22).
  - Data: `mem[20]=9`, `mem[21]=3`.
  - Required: `mem[22]=6`, stack empty, `pc=4`, and 4 `instr_done` pulses 18 cycles after the first IF.
- JZ taken and not taken:
  - Memory: `[0]=0x94`, `[1]=0xE7` (JZ 7).
  - With `mem[20]=0`: next fetch is at address 7, and no pop occurs.
  - With `mem[20]=5`: next fetch is at address 2.
- JMP wrap: `[0]=0xDF` (JMP 31), `[31]`=NOT on a preloaded 0x0F. Required: ~0x0F = 0xF0 is pushed, then the following fetch is at address 0.
- AND/ADD overflow: operands 0xF0 and 0x33. Required: AND gives 0x30; ADD gives 0x23, with no carry output.
- Reset mid-instruction: drive `rst`=0 during EXE of ADD. Required:
  - no `push` is ever issued
  - all outputs are 0 during reset
  - `pc=0`
  - IF with `mem_addr=0` occurs exactly 2 cycles after release
- Protocol check on every run:
  - `memread` and `memwrite` are never both high
  - at most one stack strobe is high per cycle
  - `stk_dout` is sampled only in the cycle after `pop`/`tos`
